fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_sync_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch stage and its prefetch queue.
package fetch_queue_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP = '0;

    // One queue entry: the fetched word and the address of the next sequential word.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instruction;
        logic [INSTR_WIDTH-1:0] pc_plus_four;
    } entry_t;

    localparam int ENTRY_WIDTH = $bits(entry_t);

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with flush. The head word is read straight from
// storage at the read pointer, so it depends on registered state only.
// The caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Write the incoming entry at the tail.
    // NOTE: storage is deliberately not reset; count and pointers alone decide
    // which words are meaningful, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Advance pointers and occupancy; reset and flush both empty the queue.
    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, drives the combinational
// instruction memory, and buffers fetched words for decode. A redirect
// flushes the queue and restarts fetch from the new address.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [31:0]                  imem_address,
    input  logic [31:0]                  imem_instruction,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         out_valid,
    output logic [INSTR_WIDTH-1:0]       out_instruction,
    output logic [31:0]                  out_pc_plus_four,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] next_seq_pc;
    logic        push;
    logic        pop;
    entry_t      push_entry;
    entry_t      head_entry;
    logic [ENTRY_WIDTH-1:0] head_bits;

    assign next_seq_pc  = fetch_pc + 32'd4;
    assign imem_address = fetch_pc;

    // Handshake: redirect overrides everything; a full queue may still accept
    // a word in the same cycle it hands one to decode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        pop        = 1'b0;
        push       = 1'b0;
        push_entry = '{instruction: imem_instruction, pc_plus_four: next_seq_pc};
        if (!redirect) begin
            pop  = out_valid && !stall;
            push = (count < FULL) || pop;
        end
    end

    // Fetch PC: reset vector, redirect target, or sequential advance on push.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (push) begin
            fetch_pc <= next_seq_pc;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .data_in (push_entry),
        .head    (head_bits),
        .count   (count)
    );

    assign head_entry = head_bits;
    assign out_valid  = (count != '0);

    // Present the head entry, or a NOP with zero PC when the queue is empty.
    always_comb begin
        out_instruction  = NOP;
        out_pc_plus_four = '0;
        if (out_valid) begin
            out_instruction  = head_entry.instruction;
            out_pc_plus_four = head_entry.pc_plus_four;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a combinational instruction memory model.
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc_plus_four;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [2:0]  cnt;
        logic [31:0] addr;
    } obs_t;

    obs_t obs;
    obs_t exp;

    localparam logic [31:0] WA = 32'hA000_0001;
    localparam logic [31:0] WB = 32'hB000_0002;
    localparam logic [31:0] WC = 32'hC000_0003;
    localparam logic [31:0] WD = 32'hD000_0004;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_instruction  (out_instruction),
        .out_pc_plus_four (out_pc_plus_four),
        .count            (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: words A..D at 0x0..0xC, elsewhere address XOR 0x5A5A_0000.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0:   return WA;
            32'h4:   return WB;
            32'h8:   return WC;
            32'hC:   return WD;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign imem_instruction = word_at(imem_address);

    function automatic obs_t snap();
        return '{valid: out_valid, instr: out_instruction, pc4: out_pc_plus_four,
                 cnt: count, addr: imem_address};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        obs = snap(); exp = '{1'b0, 32'h0, 32'h0, 3'd0, 32'h0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] words [4];
        words = '{WA, WB, WC, WD};
        for (int i = 0; i < 4; i++) begin
            step();
            obs = snap();
            exp = '{1'b1, words[i], 32'(4 * (i + 1)), 3'd1, 32'(4 * (i + 1))};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h", i,
                         obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
            end
        end
    endtask

    task automatic fill_from_reset();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) step();
        obs = snap(); exp = '{1'b1, WA, 32'h4, 3'd4, 32'h10};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL fill_saturate: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    task automatic test_stall_release();
        logic [31:0] words [4];
        fill_from_reset();
        words = '{WB, WC, WD, 32'h5A5A_0010};
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = snap();
            exp = '{1'b1, words[i], 32'(4 * (i + 2)), 3'd4, 32'(32'h14 + 4 * i)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release_%0d: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h", i,
                         obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
            end
        end
    endtask

    task automatic test_full_push_pop();
        fill_from_reset();
        stall = 1'b0;
        step();
        stall = 1'b1;
        obs = snap(); exp = '{1'b1, WB, 32'h8, 3'd4, 32'h14};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL full_push_pop: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
        step();
        obs = snap();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL full_hold: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        obs = snap(); exp = '{1'b0, 32'h0, 32'h0, 3'd0, 32'h40};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL redirect_flush: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
        step();
        obs = snap(); exp = '{1'b1, 32'h5A5A_0040, 32'h44, 3'd1, 32'h44};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL redirect_refetch: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    task automatic test_redirect_with_stall();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) step();
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        obs = snap(); exp = '{1'b0, 32'h0, 32'h0, 3'd0, 32'h80};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL redirect_stall_flush: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
        step();
        obs = snap(); exp = '{1'b1, 32'h5A5A_0080, 32'h84, 3'd1, 32'h84};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL redirect_stall_refetch: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    task automatic test_pc_wrap_unaligned();
        do_reset();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        step();
        obs = snap(); exp = '{1'b1, 32'hA5A5_FFFE, 32'h2, 3'd1, 32'h2};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL pc_wrap: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0; stall = 1'b0;
        obs = snap(); exp = '{1'b0, 32'h0, 32'h0, 3'd0, 32'h0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_clear: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
        step();
        obs = snap(); exp = '{1'b1, WA, 32'h4, 3'd1, 32'h4};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_resume_a: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
        step();
        obs = snap(); exp = '{1'b1, WB, 32'h8, 3'd1, 32'h8};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_resume_b: got v=%b i=%h p=%h c=%0d a=%h expected v=%b i=%h p=%h c=%0d a=%h",
                     obs.valid, obs.instr, obs.pc4, obs.cnt, obs.addr, exp.valid, exp.instr, exp.pc4, exp.cnt, exp.addr);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        test_reset();
        test_streaming();
        test_stall_release();
        test_full_push_pop();
        test_redirect();
        test_redirect_with_stall();
        test_pc_wrap_unaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
